fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fdpaint_pkg.sv | 32 +++
 rtl/fb_clear_seq.sv | 34 +++
 rtl/fb_arbiter.sv | 134 +++++++++++++
 tb/tb_fb_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdpaint_pkg.sv
// Shared framebuffer geometry, pixel format and arbiter types for the
// paint pipeline (arbiter, clear sequencer and vga_driver).
package fdpaint_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 8;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_CLEAR = 1'b1
    } arb_state_t;

    // Which requester owns the single RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VGA  = 2'd1,
        GNT_CLR  = 2'd2,
        GNT_WR   = 2'd3
    } grant_t;

    function automatic logic [DATA_W-1:0] rgb332(
        input logic [2:0] r,
        input logic [2:0] g,
        input logic [1:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/fb_clear_seq.sv
// Address counter for the clear-screen sweep: reloads to 0 on start,
// advances on step and parks on the last address instead of wrapping.
module fb_clear_seq
    import fdpaint_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [AW-1:0] addr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg <= '0;
        end else if (start) begin
            addr_reg <= '0;
        end else if (step && (addr_reg != LAST_ADDR)) begin
            addr_reg <= addr_reg + 1'b1;
        end
    end

    assign addr = addr_reg;
    assign last = (addr_reg == LAST_ADDR);

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win, then the clear sweep,
// then paint writes; the RAM port is driven combinationally from the grant.
module fb_arbiter
    import fdpaint_pkg::*;
#(
    parameter int FB_DEPTH = fdpaint_pkg::FB_DEPTH,
    parameter int ADDR_W   = fdpaint_pkg::ADDR_W,
    parameter int DATA_W   = fdpaint_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_req,
    input  logic [DATA_W-1:0] clr_color,
    output logic              busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_reg;
    logic [DATA_W-1:0] color_reg;
    logic              vga_valid_reg;
    logic              clr_done_reg;
    grant_t            grant;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_last;
    logic              clr_start;
    logic              clr_step;

    // Grants are masked during reset so the RAM port is idle while rst is high.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (vga_req) begin
                grant = GNT_VGA;
            end else if (state_reg == ARB_CLEAR) begin
                grant = GNT_CLR;
            end else if (wr_req) begin
                grant = GNT_WR;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (grant)
            GNT_VGA: begin
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end
            GNT_CLR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = color_reg;
            end
            GNT_WR: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign clr_start = (state_reg == ARB_IDLE) && clr_req;
    assign clr_step  = (grant == GNT_CLR);

    fb_clear_seq #(
        .DEPTH (FB_DEPTH),
        .AW    (ADDR_W)
    ) u_clear_seq (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .step  (clr_step),
        .addr  (clr_addr),
        .last  (clr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            color_reg     <= '0;
            vga_valid_reg <= 1'b0;
            clr_done_reg  <= 1'b0;
        end else begin
            vga_valid_reg <= (grant == GNT_VGA);
            clr_done_reg  <= 1'b0;
            case (state_reg)
                ARB_IDLE: begin
                    if (clr_req) begin
                        state_reg <= ARB_CLEAR;
                        color_reg <= clr_color;
                    end
                end
                ARB_CLEAR: begin
                    // Leave only once the final address has actually been written.
                    if (clr_step && clr_last) begin
                        state_reg    <= ARB_IDLE;
                        clr_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign vga_valid = vga_valid_reg;
    assign vga_data  = mem_rdata;
    assign wr_ack    = (grant == GNT_WR);
    assign busy      = (state_reg == ARB_CLEAR);
    assign clr_done  = clr_done_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: a behavioural RAM plus a reference model checked on
// every falling edge, directed scenarios and a randomized traffic phase.
module tb_fb_arbiter;

    localparam int DEPTH = 19200;

    logic       clk;
    logic       rst;
    logic       vga_req;
    logic [14:0] vga_addr;
    logic [7:0] vga_data;
    logic       vga_valid;
    logic       wr_req;
    logic [14:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic       clr_req;
    logic [7:0] clr_color;
    logic       busy;
    logic       clr_done;
    logic       mem_en;
    logic       mem_we;
    logic [14:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .busy      (busy),
        .clr_done  (clr_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Physical RAM seen by the DUT: synchronous read, one-cycle latency.
    logic [7:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] = mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected RAM image and arbiter state in plain variables.
    logic [7:0] ref_mem [0:DEPTH-1];
    bit         m_clearing = 0;
    int         m_cnt = 0;
    logic [7:0] m_color = 8'h00;
    bit         m_done_pend = 0;
    bit         m_rd_pend = 0;
    logic [7:0] m_rd_data = 8'h00;

    always @(negedge clk) begin
        bit e_en, e_we, e_ack;
        int e_addr;
        logic [7:0] e_wd;
        if (rst) begin
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_wr_ack", 32'(wr_ack), 0);
            chk("rst_vga_valid", 32'(vga_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_clr_done", 32'(clr_done), 0);
            m_clearing = 0; m_cnt = 0; m_color = 8'h00;
            m_done_pend = 0; m_rd_pend = 0;
        end else begin
            e_en = 0; e_we = 0; e_ack = 0; e_addr = 0; e_wd = 8'h00;
            if (vga_req) begin
                e_en = 1; e_addr = int'(vga_addr);
            end else if (m_clearing) begin
                e_en = 1; e_we = 1; e_addr = m_cnt; e_wd = m_color;
            end else if (wr_req) begin
                e_en = 1; e_we = 1; e_ack = 1; e_addr = int'(wr_addr); e_wd = wr_data;
            end
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            chk("wr_ack", 32'(wr_ack), 32'(e_ack));
            chk("busy", 32'(busy), 32'(m_clearing));
            chk("clr_done", 32'(clr_done), 32'(m_done_pend));
            chk("vga_valid", 32'(vga_valid), 32'(m_rd_pend));
            if (m_rd_pend) chk("vga_data", 32'(vga_data), 32'(m_rd_data));

            m_done_pend = 0;
            m_rd_pend = vga_req;
            if (vga_req) m_rd_data = ref_mem[int'(vga_addr)];
            if (e_we) ref_mem[e_addr] = e_wd;
            if (m_clearing) begin
                if (!vga_req) begin
                    if (m_cnt == DEPTH - 1) begin
                        m_clearing = 0;
                        m_done_pend = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            end else if (clr_req) begin
                m_clearing = 1; m_cnt = 0; m_color = clr_color;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] snap [0:DEPTH-1];

    initial begin
        int busy_n, done_n, bad_ack, other_n, bad_n;
        bit seen, got_ack, tog, ack_seen;
        rst = 1'b1; vga_req = 0; vga_addr = '0; wr_req = 0; wr_addr = '0;
        wr_data = '0; clr_req = 0; clr_color = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            ram[i] = v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_vga_valid", 32'(vga_valid), 0);
        chk("reset_mem_en", 32'(mem_en), 0);
        chk("reset_clr_done", 32'(clr_done), 0);
        tick();
        rst = 1'b0;
        tick();

        // Scanout read of a known pixel.
        ram[100] = 8'hE3; ref_mem[100] = 8'hE3;
        vga_req = 1; vga_addr = 15'd100;
        @(negedge clk);
        chk("read_mem_en", 32'(mem_en), 1);
        chk("read_mem_we", 32'(mem_we), 0);
        chk("read_mem_addr", 32'(mem_addr), 100);
        tick();
        vga_req = 0;
        @(negedge clk);
        chk("read_valid", 32'(vga_valid), 1);
        chk("read_data", 32'(vga_data), 32'hE3);
        tick();

        // Paint write blocked by three scanout cycles.
        wr_req = 1; wr_addr = 15'd5; wr_data = 8'h1C; vga_req = 1;
        for (int i = 0; i < 3; i++) begin
            vga_addr = 15'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            chk("blocked_wr_ack", 32'(wr_ack), 0);
            tick();
        end
        vga_req = 0;
        @(negedge clk);
        chk("wr_ack", 32'(wr_ack), 1);
        chk("wr_mem_we", 32'(mem_we), 1);
        chk("wr_mem_addr", 32'(mem_addr), 5);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h1C);
        tick();
        wr_req = 0;
        tick();
        chk("wr_ram5", 32'(ram[5]), 32'h1C);

        // Full clear to 0xFF with a paint write held pending throughout.
        clr_color = 8'hFF; clr_req = 1;
        tick();
        clr_req = 0; wr_req = 1; wr_addr = 15'd7; wr_data = 8'h55;
        busy_n = 0; done_n = 0; bad_ack = 0; seen = 0; got_ack = 0;
        for (int n = 0; n < 25000 && !seen; n++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (busy && wr_ack) bad_ack++;
            if (clr_done) begin done_n++; seen = 1; got_ack = wr_ack; end
            tick();
        end
        wr_req = 0;
        repeat (5) begin
            @(negedge clk);
            if (clr_done) done_n++;
            tick();
        end
        other_n = 0;
        for (int i = 0; i < DEPTH; i++) if (i != 7 && ram[i] == 8'hFF) other_n++;
        chk("clear_busy_cycles", 32'(busy_n), 19200);
        chk("clear_done_pulses", 32'(done_n), 1);
        chk("clear_ack_while_busy", 32'(bad_ack), 0);
        chk("clear_ack_after_done", 32'(got_ack), 1);
        chk("clear_wr_landed", 32'(ram[7]), 32'h55);
        chk("clear_ff_count", 32'(other_n), 19199);
        chk("clear_busy_after", 32'(busy), 0);

        // Clear interleaved with scanout on every other cycle.
        clr_color = 8'h1C; clr_req = 1; vga_req = 0;
        tick();
        clr_req = 0;
        busy_n = 0; seen = 0; tog = 1;
        for (int n = 0; n < 45000 && !seen; n++) begin
            vga_req = tog;
            vga_addr = 15'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            if (busy) busy_n++;
            if (clr_done) seen = 1;
            tick();
            tog = !tog;
        end
        vga_req = 0;
        chk("interleave_done_seen", 32'(seen), 1);
        chk("interleave_busy_cycles", 32'(busy_n), 38400);
        tick();

        // Reset after 500 addresses have been cleared.
        for (int i = 0; i < DEPTH; i++) snap[i] = ram[i];
        clr_color = 8'h3A; clr_req = 1;
        tick();
        clr_req = 0;
        repeat (500) tick();
        rst = 1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        tick();
        rst = 0;
        done_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (clr_done) done_n++;
            tick();
        end
        bad_n = 0;
        for (int i = 0; i < 500; i++) if (ram[i] != 8'h3A) bad_n++;
        chk("abort_cleared_part", 32'(bad_n), 0);
        bad_n = 0;
        for (int i = 500; i < DEPTH; i++) if (ram[i] != snap[i]) bad_n++;
        chk("abort_untouched_part", 32'(bad_n), 0);
        chk("abort_no_done", 32'(done_n), 0);
        chk("abort_busy_after", 32'(busy), 0);

        // Randomized traffic; the model process checks every cycle.
        ack_seen = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 399) == 0);
            vga_req = ($urandom_range(0, 2) == 0);
            vga_addr = 15'($urandom_range(0, DEPTH - 1));
            clr_req = ($urandom_range(0, 299) == 0);
            clr_color = 8'($urandom);
            if (!wr_req || ack_seen) begin
                wr_req = 1'($urandom);
                wr_addr = 15'($urandom_range(0, DEPTH - 1));
                wr_data = 8'($urandom);
            end
            @(negedge clk);
            ack_seen = wr_ack;
            tick();
        end
        rst = 1; vga_req = 0; wr_req = 0; clr_req = 0;
        tick();
        rst = 0;
        tick();

        bad_n = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad_n++;
        chk("final_ram_image", 32'(bad_n), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
